// File: rtl/token_sched_pkg.sv
// Shared types and defaults for the weighted token lane scheduler.
package token_sched_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_W_WIDTH = 4;
  localparam int DEF_LANE_W  = $clog2(DEF_LANES);

  typedef logic [DEF_LANE_W-1:0]         lane_idx_t;
  typedef logic [DEF_W_WIDTH-1:0]        weight_t;
  typedef weight_t [DEF_LANES-1:0]       weight_vec_t;

  // Every lane starts with weight 1, which gives plain round-robin.
  localparam weight_t DEF_WEIGHT = weight_t'(1);

endpackage

// File: rtl/token_lane_finder.sv
// Combinational search for the next lane with a nonzero weight, starting
// just after i_start and wrapping cyclically. o_wrap flags that the found
// lane index is at or below the start index.
module token_lane_finder #(
  parameter int N_LANES = 4,
  parameter int W_WIDTH = 4
) (
  input  logic [N_LANES-1:0][W_WIDTH-1:0] i_weights,
  input  logic [$clog2(N_LANES)-1:0]      i_start,
  output logic [$clog2(N_LANES)-1:0]      o_next,
  output logic                            o_wrap,
  output logic                            o_anyActive
);

  localparam int LANE_W = $clog2(N_LANES);

  logic w_found;
  int   w_idx;

  assign o_anyActive = |i_weights;

  // Scan the lanes after i_start in cyclic order; the first nonzero weight wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 0;
    o_next  = '0;
    for (int i = 1; i <= N_LANES; i++) begin
      w_idx = (int'(i_start) + i) % N_LANES;
      if (!w_found && (i_weights[w_idx] != '0)) begin
        w_found = 1'b1;
        o_next  = LANE_W'(w_idx);
      end
    end
    o_wrap = w_found && (o_next <= i_start);
  end

endmodule

// File: rtl/token_lane_scheduler.sv
// Weighted round-robin steering of a serial token stream onto N lanes.
// Weights are staged in a shadow bank and copied to the active bank only at
// a round boundary, so a round in progress always finishes with the weights
// it started with.
module token_lane_scheduler
  import token_sched_pkg::*;
#(
  parameter int N_LANES = DEF_LANES,
  parameter int W_WIDTH = DEF_W_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a,
  output logic [N_LANES-1:0]         b,
  output logic                       drop,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(N_LANES)-1:0] cfg_lane,
  input  logic [W_WIDTH-1:0]         cfg_weight,
  input  logic                       cfg_commit,
  output logic                       commit_pending,
  output logic [$clog2(N_LANES)-1:0] cur_lane
);

  localparam int LANE_W = $clog2(N_LANES);

  logic [N_LANES-1:0][W_WIDTH-1:0] r_active;
  logic [N_LANES-1:0][W_WIDTH-1:0] r_shadow;
  logic [LANE_W-1:0]               r_cur;
  logic [W_WIDTH-1:0]              r_cnt;
  logic                            r_atStart;
  logic                            r_pending;

  logic [LANE_W-1:0] w_nextLane;
  logic              w_nextWrap;
  logic              w_anyActive;
  logic [LANE_W-1:0] w_firstLane;
  logic              w_firstWrap;
  logic              w_shadowAny;
  logic              w_unused;
  logic              w_laneOk;
  logic              w_routed;
  logic              w_advance;
  logic              w_wrap;
  logic              w_commitNow;

  // Next lane for an in-round advance, based on the active weights.
  token_lane_finder #(.N_LANES(N_LANES), .W_WIDTH(W_WIDTH)) u_advFinder (
    .i_weights   (r_active),
    .i_start     (r_cur),
    .o_next      (w_nextLane),
    .o_wrap      (w_nextWrap),
    .o_anyActive (w_anyActive)
  );

  // Searching from the last lane yields the lowest nonzero shadow lane.
  token_lane_finder #(.N_LANES(N_LANES), .W_WIDTH(W_WIDTH)) u_firstFinder (
    .i_weights   (r_shadow),
    .i_start     (LANE_W'(N_LANES - 1)),
    .o_next      (w_firstLane),
    .o_wrap      (w_firstWrap),
    .o_anyActive (w_shadowAny)
  );

  assign w_unused = w_firstWrap ^ w_shadowAny;

  generate
    if ((1 << LANE_W) == N_LANES) begin : g_laneAlwaysOk
      assign w_laneOk = 1'b1;
    end else begin : g_laneRangeCheck
      assign w_laneOk = (cfg_lane < LANE_W'(N_LANES));
    end
  endgenerate

  assign w_routed    = !rst && a && w_anyActive;
  assign w_advance   = w_routed && ((r_cnt + W_WIDTH'(1)) == r_active[r_cur]);
  assign w_wrap      = w_advance && w_nextWrap;
  assign w_commitNow = r_pending && ((w_routed && w_wrap) || (!a && r_atStart) || !w_anyActive);

  assign drop           = !rst && a && !w_anyActive;
  assign cfg_ready      = !r_pending;
  assign commit_pending = r_pending;
  assign cur_lane       = r_cur;

  // Steer a routed token to the current lane as a one-hot pattern.
  always_comb begin
    b = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (w_routed && (r_cur == LANE_W'(i))) begin
        b[i] = 1'b1;
      end
    end
  end

  // Weight banks, round pointer/counter and commit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        r_active[i] <= W_WIDTH'(DEF_WEIGHT);
        r_shadow[i] <= W_WIDTH'(DEF_WEIGHT);
      end
      r_cur     <= '0;
      r_cnt     <= '0;
      r_atStart <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      if (cfg_valid && !r_pending && w_laneOk) begin
        r_shadow[cfg_lane] <= cfg_weight;
      end
      if (w_commitNow) begin
        r_active  <= r_shadow;
        r_cnt     <= '0;
        r_cur     <= w_firstLane;
        r_pending <= 1'b0;
        r_atStart <= 1'b1;
      end else begin
        if (w_routed) begin
          if (w_advance) begin
            r_cur     <= w_nextLane;
            r_cnt     <= '0;
            r_atStart <= w_nextWrap;
          end else begin
            r_cnt     <= r_cnt + W_WIDTH'(1);
            r_atStart <= 1'b0;
          end
        end
        if (cfg_commit && !r_pending) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_token_lane_scheduler.sv
// Directed self-checking bench for token_lane_scheduler (4 lanes, 4-bit weights).
module tb_token_lane_scheduler;

  logic       clk;
  logic       rst;
  logic       a;
  logic [3:0] b;
  logic       drop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_lane;
  logic [3:0] cfg_weight;
  logic       cfg_commit;
  logic       commit_pending;
  logic [1:0] cur_lane;

  int checks;
  int errors;

  token_lane_scheduler #(.N_LANES(4), .W_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .drop           (drop),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_lane       (cfg_lane),
    .cfg_weight     (cfg_weight),
    .cfg_commit     (cfg_commit),
    .commit_pending (commit_pending),
    .cur_lane       (cur_lane)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle with token input aVal; checks the combinational outputs before the edge.
  task automatic applyStimulus(input logic aVal, input logic [3:0] expB, input logic expDrop, input string tag);
    a = aVal;
    #2;
    checkOutput({tag, ".b"}, 32'(b), 32'(expB));
    checkOutput({tag, ".drop"}, 32'(drop), 32'(expDrop));
    @(posedge clk);
    #1;
    a = 1'b0;
  endtask

  // One configuration cycle with a=0.
  task automatic cfgCycle(input logic valid, input logic [1:0] lane, input logic [3:0] weight, input logic commit);
    cfg_valid  = valid;
    cfg_lane   = lane;
    cfg_weight = weight;
    cfg_commit = commit;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  // Reset for one edge with a token offered, which must not be routed.
  task automatic doReset(input string tag);
    rst = 1'b1;
    a   = 1'b1;
    #2;
    checkOutput({tag, ".rstB"}, 32'(b), 32'd0);
    checkOutput({tag, ".rstDrop"}, 32'(drop), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a   = 1'b0;
  endtask

  initial begin
    logic [3:0] seq1 [8];
    logic [3:0] seq2 [7];
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    a          = 1'b0;
    cfg_valid  = 1'b0;
    cfg_lane   = '0;
    cfg_weight = '0;
    cfg_commit = 1'b0;
    seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset.pending", 32'(commit_pending), 32'd0);
    checkOutput("reset.cur", 32'(cur_lane), 32'd0);
    checkOutput("reset.ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;

    // Test 1: default weights give plain round-robin.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, seq1[i], 1'b0, "t1");

    // Test 2: weights {3,0,1,2}.
    doReset("t2");
    cfgCycle(1'b1, 2'd0, 4'd3, 1'b0);
    cfgCycle(1'b1, 2'd1, 4'd0, 1'b0);
    cfgCycle(1'b1, 2'd2, 4'd1, 1'b0);
    cfgCycle(1'b1, 2'd3, 4'd2, 1'b1);
    checkOutput("t2.pending", 32'(commit_pending), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0, "t2.idle");
    checkOutput("t2.applied", 32'(commit_pending), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, seq2[i], 1'b0, "t2");

    // Test 3: all-zero weights drop every token.
    doReset("t3");
    cfgCycle(1'b1, 2'd0, 4'd0, 1'b0);
    cfgCycle(1'b1, 2'd1, 4'd0, 1'b0);
    cfgCycle(1'b1, 2'd2, 4'd0, 1'b0);
    cfgCycle(1'b1, 2'd3, 4'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, "t3.idle");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0000, 1'b1, "t3");
    checkOutput("t3.ready", 32'(cfg_ready), 32'd1);
    checkOutput("t3.cur", 32'(cur_lane), 32'd0);

    // Test 4: commit requested mid-round waits for the wrap.
    doReset("t4");
    applyStimulus(1'b1, 4'b0001, 1'b0, "t4.first");
    checkOutput("t4.cur1", 32'(cur_lane), 32'd1);
    cfgCycle(1'b1, 2'd0, 4'd2, 1'b1);
    checkOutput("t4.pendA", 32'(commit_pending), 32'd1);
    applyStimulus(1'b1, 4'b0010, 1'b0, "t4.l1");
    checkOutput("t4.pendB", 32'(commit_pending), 32'd1);
    applyStimulus(1'b1, 4'b0100, 1'b0, "t4.l2");
    checkOutput("t4.pendC", 32'(commit_pending), 32'd1);
    applyStimulus(1'b1, 4'b1000, 1'b0, "t4.l3");
    checkOutput("t4.pendD", 32'(commit_pending), 32'd0);
    checkOutput("t4.cur0", 32'(cur_lane), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, "t4.n0a");
    applyStimulus(1'b1, 4'b0001, 1'b0, "t4.n0b");
    applyStimulus(1'b1, 4'b0010, 1'b0, "t4.n1");

    // Test 5a: write refused while pending.
    doReset("t5");
    applyStimulus(1'b1, 4'b0001, 1'b0, "t5.first");
    cfgCycle(1'b0, 2'd0, 4'd0, 1'b1);
    cfg_valid  = 1'b1;
    cfg_lane   = 2'd2;
    cfg_weight = 4'd7;
    #2;
    checkOutput("t5.ready", 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    applyStimulus(1'b1, 4'b0010, 1'b0, "t5.l1");
    applyStimulus(1'b1, 4'b0100, 1'b0, "t5.l2");
    applyStimulus(1'b1, 4'b1000, 1'b0, "t5.l3");
    checkOutput("t5.applied", 32'(commit_pending), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, seq1[i], 1'b0, "t5.rr");

    // Test 5b: reset discards a pending commit.
    doReset("t5b");
    applyStimulus(1'b1, 4'b0001, 1'b0, "t5b.first");
    cfgCycle(1'b1, 2'd0, 4'd5, 1'b1);
    checkOutput("t5b.pend", 32'(commit_pending), 32'd1);
    doReset("t5b.mid");
    checkOutput("t5b.pendClr", 32'(commit_pending), 32'd0);
    checkOutput("t5b.cur", 32'(cur_lane), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, "t5b.w0");
    applyStimulus(1'b1, 4'b0010, 1'b0, "t5b.w1");

    // Test 6: idle commit with same-cycle write applies on the next edge.
    doReset("t6");
    cfgCycle(1'b1, 2'd1, 4'd0, 1'b1);
    checkOutput("t6.pend", 32'(commit_pending), 32'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0, "t6.idle");
    checkOutput("t6.applied", 32'(commit_pending), 32'd0);
    applyStimulus(1'b1, 4'b0001, 1'b0, "t6.l0");
    applyStimulus(1'b1, 4'b0100, 1'b0, "t6.l2");
    applyStimulus(1'b1, 4'b1000, 1'b0, "t6.l3");
    applyStimulus(1'b1, 4'b0001, 1'b0, "t6.l0b");

    // Test 6b: commit start lane is the lowest nonzero shadow lane.
    doReset("t6b");
    cfgCycle(1'b1, 2'd0, 4'd0, 1'b0);
    cfgCycle(1'b1, 2'd1, 4'd0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0, "t6b.idle");
    checkOutput("t6b.cur", 32'(cur_lane), 32'd2);
    applyStimulus(1'b1, 4'b0100, 1'b0, "t6b.l2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
